// File: rtl/capture_controller.sv
// Host command sequencer: decodes UART commands, holds capture config,
// arms the sampler and streams the sample buffer back in trigger order.
module capture_controller #(
  parameter int          SAMPLE_DEPTH = 8,
  parameter int          WIDTH        = 8,
  parameter logic [15:0] DEFAULT_DIV  = 16'd1
) (
  input  logic                    clk_50mhz,
  input  logic                    reset,
  input  logic                    rx_ready,
  input  logic [7:0]              rx_data,
  input  logic                    tx_active,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  output logic                    smp_activate,
  input  logic                    smp_done,
  input  logic [SAMPLE_DEPTH-1:0] smp_offset,
  output logic [15:0]             clk_div,
  output logic [WIDTH-1:0]        trig_level,
  output logic [SAMPLE_DEPTH-1:0] rd_addr,
  input  logic [WIDTH-1:0]        rd_data,
  output logic                    busy
);

  typedef enum logic [3:0] {
    IDLE, ARG_LO, ARG_HI, ARG_LVL,
    ARMED, RELEASE,
    RD_ADDR, RD_WAIT, RD_LATCH,
    TX_REQ, TX_BUSY
  } state_t;

  localparam logic [SAMPLE_DEPTH-1:0] HALF =
    {1'b1, {(SAMPLE_DEPTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LVL_RST =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_nx;

  logic [7:0]              div_lo;
  logic [SAMPLE_DEPTH-1:0] trig_ptr;
  logic                    valid;
  logic                    streaming;
  logic                    seen_active;
  logic [SAMPLE_DEPTH:0]   count;
  logic [SAMPLE_DEPTH:0]   count_nx;
  logic                    last;
  logic                    tx_done;
  logic [15:0]             div_new;

  assign count_nx = count + 1'b1;
  assign last     = count_nx[SAMPLE_DEPTH];
  assign tx_done  = seen_active && !tx_active;
  assign div_new  = {rx_data, div_lo};

  always_ff @(posedge clk_50mhz) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (rx_ready) begin
          case (rx_data)
            8'h01:   state_nx = ARG_LO;
            8'h02:   state_nx = ARG_LVL;
            8'h03:   state_nx = ARMED;
            8'h04:   state_nx = valid ? RD_ADDR : TX_REQ;
            8'h05:   state_nx = TX_REQ;
            default: state_nx = IDLE;
          endcase
        end
      end
      ARG_LO:   if (rx_ready) state_nx = ARG_HI;
      ARG_HI:   if (rx_ready) state_nx = IDLE;
      ARG_LVL:  if (rx_ready) state_nx = IDLE;
      ARMED:    if (smp_done) state_nx = RELEASE;
      RELEASE:  if (!smp_done && !tx_active) state_nx = IDLE;
      RD_ADDR:  state_nx = RD_WAIT;
      RD_WAIT:  state_nx = RD_LATCH;
      RD_LATCH: state_nx = TX_REQ;
      TX_REQ:   if (!tx_active) state_nx = TX_BUSY;
      TX_BUSY: begin
        if (tx_done)
          state_nx = (streaming && !last) ? RD_ADDR : IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    tx_start     = (state == TX_REQ) && !tx_active;
    smp_activate = (state == ARMED);
    busy         = (state != IDLE);
  end

  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      tx_data     <= 8'h00;
      clk_div     <= DEFAULT_DIV;
      trig_level  <= LVL_RST;
      rd_addr     <= '0;
      div_lo      <= 8'h00;
      trig_ptr    <= '0;
      valid       <= 1'b0;
      streaming   <= 1'b0;
      seen_active <= 1'b0;
      count       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rx_ready && rx_data == 8'h04) begin
            streaming <= valid;
            count     <= '0;
            if (valid) rd_addr <= trig_ptr - HALF;
            else       tx_data <= 8'hEE;
          end
          if (rx_ready && rx_data == 8'h05) begin
            streaming <= 1'b0;
            tx_data   <= {7'b1010000, valid};
          end
        end
        ARG_LO: if (rx_ready) div_lo <= rx_data;
        ARG_HI: begin
          if (rx_ready)
            clk_div <= (div_new == 16'd0) ? 16'd1 : div_new;
        end
        ARG_LVL: if (rx_ready) trig_level <= WIDTH'(rx_data);
        ARMED: begin
          if (smp_done) begin
            trig_ptr <= smp_offset;
            valid    <= 1'b1;
          end
        end
        // RAM output for rd_addr is valid here after its 1-cycle latency
        RD_WAIT: tx_data <= 8'(rd_data);
        TX_REQ:  seen_active <= 1'b0;
        TX_BUSY: begin
          seen_active <= seen_active | tx_active;
          if (tx_done && streaming) begin
            count   <= count_nx;
            rd_addr <= rd_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_controller.sv
// Randomized self-checking bench for capture_controller with UART,
// sampler and RAM models plus a command-level reference model.
module tb_capture_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        tx_active;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        smp_activate;
  logic        smp_done;
  logic [7:0]  smp_offset;
  logic [15:0] clk_div;
  logic [7:0]  trig_level;
  logic [7:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        busy;

  always #10 clk = ~clk;

  capture_controller dut (
    .clk_50mhz    (clk),
    .reset        (reset),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .tx_active    (tx_active),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .smp_activate (smp_activate),
    .smp_done     (smp_done),
    .smp_offset   (smp_offset),
    .clk_div      (clk_div),
    .trig_level   (trig_level),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [7:0] mem [256];
  always @(posedge clk) rd_data <= mem[rd_addr];

  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  // UART transmitter model: goes busy the cycle after tx_start
  int cnt = 0;
  bit prev_start = 0;
  initial tx_active = 1'b0;
  always @(negedge clk) begin
    if (prev_start) check("tx_start_width", tx_start, 0);
    if (tx_start) begin
      check("tx_start_vs_active", tx_active, 0);
      check("tx_start_vs_armed", smp_activate, 0);
      got.push_back(tx_data);
    end
    if (cnt > 0) begin
      tx_active = 1'b1;
      cnt--;
    end else begin
      tx_active = 1'b0;
    end
    if (tx_start) cnt = $urandom_range(3, 8);
    prev_start = tx_start;
  end

  bit         valid_m;
  logic [7:0] trig_m;
  logic [15:0] div_m;
  logic [7:0] lvl_m;

  task automatic model_reset();
    valid_m = 0;
    trig_m  = 8'h00;
    div_m   = 16'd1;
    lvl_m   = 8'h80;
  endtask

  task automatic send(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_count"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (got[i] !== exp_q[i]) check({tag, "_byte"}, got[i], exp_q[i]);
    if (n > 0) check({tag, "_first"}, got[0], exp_q[0]);
    got.delete();
    exp_q.delete();
    check({tag, "_busy"}, busy, 0);
    check({tag, "_div"}, clk_div, div_m);
    check({tag, "_lvl"}, trig_level, lvl_m);
  endtask

  task automatic cmd_status();
    exp_q.push_back({7'b1010000, valid_m});
    send(8'h05);
    wait_idle();
    compare("status");
  endtask

  task automatic cmd_read();
    if (valid_m)
      for (int i = 0; i < 256; i++)
        exp_q.push_back(mem[8'(int'(trig_m) - 128 + i)]);
    else
      exp_q.push_back(8'hEE);
    send(8'h04);
    wait_idle();
    compare("read");
  endtask

  task automatic cmd_div(input logic [15:0] v);
    send(8'h01);
    send(v[7:0]);
    send(v[15:8]);
    div_m = (v == 16'd0) ? 16'd1 : v;
    check("div_update", clk_div, div_m);
    wait_idle();
    compare("setdiv");
  endtask

  task automatic cmd_lvl(input logic [7:0] v);
    send(8'h02);
    send(v);
    lvl_m = v;
    wait_idle();
    compare("setlvl");
  endtask

  task automatic cmd_arm(input logic [7:0] off);
    send(8'h03);
    check("act_rise", smp_activate, 1);
    repeat ($urandom_range(0, 3)) begin
      if ($urandom_range(0, 1) == 1) send(8'h55);
      else                           send(8'($urandom));
    end
    @(negedge clk);
    check("act_hold", smp_activate, 1);
    smp_done   = 1'b1;
    smp_offset = off;
    @(negedge clk);
    check("act_fall", smp_activate, 0);
    check("release_busy", busy, 1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    smp_done   = 1'b0;
    smp_offset = 8'($urandom);
    valid_m = 1;
    trig_m  = off;
    wait_idle();
    compare("arm");
  endtask

  task automatic cmd_junk();
    logic [7:0] b;
    b = 8'($urandom_range(6, 255));
    if ($urandom_range(0, 3) == 0) b = 8'h00;
    send(b);
    check("junk_busy", busy, 0);
    wait_idle();
    compare("junk");
  endtask

  initial begin
    int k;
    reset      = 1'b1;
    rx_ready   = 1'b0;
    rx_data    = 8'h00;
    smp_done   = 1'b0;
    smp_offset = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_act", smp_activate, 0);
    check("rst_div", clk_div, 16'd1);
    check("rst_lvl", trig_level, 8'h80);
    check("rst_rd_addr", rd_addr, 8'h00);
    check("rst_busy", busy, 0);

    cmd_status();
    cmd_div(16'h1234);
    cmd_div(16'h0000);
    cmd_read();
    cmd_arm(8'h10);
    cmd_status();
    cmd_read();

    // reset in the middle of a readout
    send(8'h04);
    k = 0;
    while (got.size() < 40 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("midread_progress", got.size() >= 40, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_tx_start", tx_start, 0);
    check("midrst_busy", busy, 0);
    check("midrst_act", smp_activate, 0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    got.delete();
    exp_q.delete();
    model_reset();
    cmd_status();

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0, 1:    cmd_div(16'($urandom));
        2, 3:    cmd_lvl(8'($urandom));
        4:       cmd_arm(8'($urandom));
        5:       if (it % 8 == 5) cmd_read(); else cmd_status();
        6, 7:    cmd_status();
        default: cmd_junk();
      endcase
    end
    cmd_read();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
